donut_march_sched: RTL and testbench

Issue/retire scheduler that shares a pool of `N_UNITS` fixed-latency donut ray-march units (`donuthit`) so the renderer can produce more than one pixel per `UNIT_CYCLES` clocks. It accepts ray queries from the ray-stepping logic and starts them on units in round-robin order. Results come back in issue order; the block converts them to 6-bit luma and buffers them in a small FIFO that feeds the VGA pixel path.

---
 rtl/donut_pkg.sv | 18 +
 rtl/donut_pix_fifo.sv | 62 ++++++
 rtl/donut_march_sched.sv | 129 ++++++++++++
 tb/tb_donut_march_sched.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/donut_pkg.sv
// rtl/donut_pkg.sv - shared types and helpers for the donut ray-march scheduler
package donut_pkg;

  localparam int LUMA_W          = 6;
  localparam int DEF_UNIT_CYCLES = 8;

  // One pixel as handed to the VGA pixel path.
  typedef struct packed {
    logic              hit;
    logic [LUMA_W-1:0] luma;
  } pix_t;

  // Takes light[13:8] (signed -32..31); flipping the sign bit offsets it to 0..63.
  function automatic logic [LUMA_W-1:0] light_to_luma(input logic [5:0] light_13_8);
    return {~light_13_8[5], light_13_8[4:0]};
  endfunction

endpackage

// File: rtl/donut_pix_fifo.sv
// rtl/donut_pix_fifo.sv - first-word-fall-through pixel FIFO with flush and occupancy count
module donut_pix_fifo
  import donut_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  pix_t          din,
  input  logic          pop,
  output pix_t          dout,
  output logic          valid,
  output logic [CW-1:0] count
);

  pix_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Head is gated by valid so an empty FIFO (including during reset) shows zeros.
  assign valid   = (count != '0);
  assign dout    = valid ? mem[rd_ptr] : '0;
  assign do_push = push && !flush;
  assign do_pop  = pop && valid && !flush;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Storage write; contents never need clearing because the head is masked when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; flush empties the buffer and wins over push/pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wrap_inc(wr_ptr);
      if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/donut_march_sched.sv
// rtl/donut_march_sched.sv - round-robin issue/retire scheduler for the donut march unit pool
module donut_march_sched
  import donut_pkg::*;
#(
  parameter int N_UNITS     = 4,
  parameter int UNIT_CYCLES = DEF_UNIT_CYCLES,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  output logic [N_UNITS-1:0]    unit_start,
  input  logic [N_UNITS-1:0]    unit_hit,
  input  logic [16*N_UNITS-1:0] unit_light,
  output logic                  pix_valid,
  output logic                  pix_hit,
  output logic [LUMA_W-1:0]     pix_luma,
  input  logic                  pix_ready,
  output logic                  underrun
);

  localparam int PW = (N_UNITS > 1) ? $clog2(N_UNITS) : 1;
  localparam int BW = $clog2(UNIT_CYCLES + 1);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [PW-1:0]      ptr;
  logic [BW-1:0]      busy [N_UNITS];
  logic [CW-1:0]      inflight;
  logic [CW-1:0]      fifo_count;
  logic [N_UNITS-1:0] unit_free;
  logic               issue;
  logic               ret_valid;
  pix_t               ret_pix;
  pix_t               head;
  logic [N_UNITS-1:0] unused_light;

  // A unit can take a new query when idle or in the cycle its result is being sampled.
  always_comb begin
    unit_free = '0;
    for (int i = 0; i < N_UNITS; i++) unit_free[i] = (busy[i] <= BW'(1));
  end

  // Credits count both in-flight work and buffered pixels, so the FIFO can never overflow.
  assign req_ready = !rst && !flush && unit_free[ptr] &&
                     ((int'(inflight) + int'(fifo_count)) < FIFO_DEPTH);
  assign issue     = req_valid && req_ready;

  // One-hot start pulse to the unit under the round-robin pointer.
  always_comb begin
    unit_start = '0;
    if (issue) unit_start[ptr] = 1'b1;
  end

  // Retire mux: fixed latency means at most one unit sits at count 1 in any cycle.
  always_comb begin
    ret_valid = 1'b0;
    ret_pix   = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (busy[i] == BW'(1)) begin
        ret_valid    = 1'b1;
        ret_pix.hit  = unit_hit[i];
        ret_pix.luma = light_to_luma(unit_light[16*i+8 +: 6]);
      end
    end
  end

  // Only light[13:8] feeds the luma; the remaining bits are deliberately ignored.
  for (genvar g = 0; g < N_UNITS; g++) begin : g_light_sink
    assign unused_light[g] = ^{unit_light[16*g+14 +: 2], unit_light[16*g +: 8]};
  end

  // Busy counters: loaded on start, count down to idle; flush forgets all work.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_UNITS; i++) busy[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < N_UNITS; i++) busy[i] <= '0;
    end else begin
      for (int i = 0; i < N_UNITS; i++) begin
        if (unit_start[i])       busy[i] <= BW'(UNIT_CYCLES);
        else if (busy[i] != '0)  busy[i] <= busy[i] - 1'b1;
      end
    end
  end

  // Round-robin pointer and in-flight count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      inflight <= '0;
    end else if (flush) begin
      ptr      <= '0;
      inflight <= '0;
    end else begin
      if (issue) ptr <= (ptr == PW'(N_UNITS - 1)) ? '0 : ptr + 1'b1;
      case ({issue, ret_valid})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: ;
      endcase
    end
  end

  // Underrun flags a consumer pull against an empty buffer, one cycle late.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) underrun <= 1'b0;
    else     underrun <= pix_ready && !pix_valid;
  end

  donut_pix_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (ret_valid),
    .din   (ret_pix),
    .pop   (pix_ready),
    .dout  (head),
    .valid (pix_valid),
    .count (fifo_count)
  );

  assign pix_hit  = head.hit;
  assign pix_luma = head.luma;

endmodule

// File: tb/tb_donut_march_sched.sv
// tb/tb_donut_march_sched.sv - self-checking bench for the donut march scheduler
module tb_donut_march_sched;
  import donut_pkg::*;

  localparam int NU = 4;
  localparam int UC = 8;
  localparam int FD = 8;

  logic            clk;
  logic            rst;
  logic            flush;
  logic            req_valid;
  logic            req_ready;
  logic [NU-1:0]   unit_start;
  logic [NU-1:0]   unit_hit;
  logic [16*NU-1:0] unit_light;
  logic            pix_valid;
  logic            pix_hit;
  logic [5:0]      pix_luma;
  logic            pix_ready;
  logic            underrun;

  donut_march_sched #(
    .N_UNITS     (NU),
    .UNIT_CYCLES (UC),
    .FIFO_DEPTH  (FD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .unit_start (unit_start),
    .unit_hit   (unit_hit),
    .unit_light (unit_light),
    .pix_valid  (pix_valid),
    .pix_hit    (pix_hit),
    .pix_luma   (pix_luma),
    .pix_ready  (pix_ready),
    .underrun   (underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        hit;
    logic [15:0] light;
    logic [5:0]  luma;
  } luma_vec_t;

  typedef struct {
    logic          rv;
    logic          rdy;
    logic [NU-1:0] st;
  } strm_vec_t;

  luma_vec_t   luma_tab [4];
  strm_vec_t   strm_tab [12];

  int          n_chk;
  int          n_pass;
  int          mcnt [NU];
  logic [16:0] mpay [NU];
  logic [16:0] next_pay;
  logic [6:0]  q [$];
  logic        obs_ready, obs_pv, obs_hit, obs_und, obs_acc;
  logic [NU-1:0] obs_start;
  logic [5:0]  obs_luma;
  int          pv_seen;
  int          acc_n;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_chk++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, want);
  endtask

  // Reference luma: treat light[13:8] as a signed 6-bit number and add 32.
  function automatic logic [5:0] ref_luma(input logic [15:0] lt);
    logic [5:0] f;
    int         v;
    f = lt[13:8];
    v = int'($signed(f)) + 32;
    return v[5:0];
  endfunction

  function automatic logic [16:0] rand_pay();
    logic [16:0] p;
    p[16]   = 1'($urandom_range(0, 1));
    p[15:0] = 16'($urandom);
    return p;
  endfunction

  // One clock cycle: called just after a negedge with this cycle's inputs set.
  task automatic tick();
    logic       acc;
    logic [6:0] e;
    for (int i = 0; i < NU; i++) begin
      unit_hit[i]            = (mcnt[i] == 1) ? mpay[i][16]   : ~mpay[i][16];
      unit_light[16*i +: 16] = (mcnt[i] == 1) ? mpay[i][15:0] : ~mpay[i][15:0];
    end
    #1;
    obs_ready = req_ready;
    obs_start = unit_start;
    obs_pv    = pix_valid;
    obs_hit   = pix_hit;
    obs_luma  = pix_luma;
    obs_und   = underrun;
    acc       = req_valid && req_ready;
    obs_acc   = acc;
    if (pix_valid) pv_seen++;
    if (flush) begin
      q.delete();
    end else if (pix_valid && pix_ready) begin
      n_chk++;
      if (q.size() == 0) begin
        $display("FAIL sb_order: got pixel %0h, expected none", {pix_hit, pix_luma});
      end else begin
        e = q.pop_front();
        if ({pix_hit, pix_luma} === e) n_pass++;
        else $display("FAIL sb_order: got pixel %0h expected %0h", {pix_hit, pix_luma}, e);
      end
    end
    if (acc) q.push_back({next_pay[16], ref_luma(next_pay[15:0])});
    @(posedge clk);
    for (int i = 0; i < NU; i++) begin
      if (acc && obs_start[i]) begin
        mcnt[i] = UC;
        mpay[i] = next_pay;
      end else if (mcnt[i] > 0) begin
        mcnt[i] = mcnt[i] - 1;
      end
    end
    if (acc) next_pay = rand_pay();
    @(negedge clk);
  endtask

  task automatic do_flush();
    flush     = 1'b1;
    req_valid = 1'b0;
    tick();
    flush     = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    pv_seen = 0;
    acc_n = 0;
    luma_tab[0] = '{1'b1, 16'h1F00, 6'd63};
    luma_tab[1] = '{1'b0, 16'hE000, 6'd0};
    luma_tab[2] = '{1'b1, 16'h0000, 6'd32};
    luma_tab[3] = '{1'b0, 16'h0A7F, 6'd42};
    for (int i = 0; i < 12; i++) begin
      strm_tab[i].rv  = 1'b1;
      strm_tab[i].rdy = ((i % 8) < 4);
      strm_tab[i].st  = strm_tab[i].rdy ? NU'(1 << (i % 4)) : '0;
    end
    for (int i = 0; i < NU; i++) begin
      mcnt[i] = 0;
      mpay[i] = '0;
    end
    next_pay   = rand_pay();
    rst        = 1'b1;
    flush      = 1'b0;
    req_valid  = 1'b1;
    pix_ready  = 1'b1;
    unit_hit   = '0;
    unit_light = '0;

    // Reset state with requests and pulls pending.
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("reset_state", {req_ready, unit_start, pix_valid, pix_hit, pix_luma, underrun}, 0);
    req_valid = 1'b0;
    pix_ready = 1'b0;
    rst       = 1'b0;
    @(negedge clk);

    // Single queries: exact latency and luma mapping, one unit per entry.
    for (int k = 0; k < 4; k++) begin
      next_pay  = {luma_tab[k].hit, luma_tab[k].light};
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0;
      chk("single_start", obs_start, 1 << k);
      for (int j = 1; j <= UC; j++) tick();
      chk("single_early", obs_pv, 0);
      pix_ready = 1'b1;
      tick();
      pix_ready = 1'b0;
      chk("single_valid", obs_pv, 1);
      chk("single_hit", obs_hit, luma_tab[k].hit);
      chk("single_luma", obs_luma, luma_tab[k].luma);
    end

    // Streaming with the consumer always ready.
    do_flush();
    pix_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      req_valid = strm_tab[i].rv;
      tick();
      chk("stream_ready", obs_ready, strm_tab[i].rdy);
      chk("stream_start", obs_start, strm_tab[i].st);
    end
    req_valid = 1'b0;
    repeat (20) tick();
    chk("stream_drain", q.size(), 0);

    // Backpressure: credits stop at FIFO_DEPTH, one pop frees one credit.
    do_flush();
    pix_ready = 1'b0;
    req_valid = 1'b1;
    acc_n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      acc_n += int'(obs_acc);
    end
    chk("bp_accepts", acc_n, 8);
    chk("bp_ready_low", obs_ready, 0);
    pix_ready = 1'b1;
    tick();
    pix_ready = 1'b0;
    acc_n = int'(obs_acc);
    for (int i = 0; i < 10; i++) begin
      tick();
      acc_n += int'(obs_acc);
    end
    chk("bp_one_more", acc_n, 1);
    req_valid = 1'b0;
    pix_ready = 1'b1;
    repeat (30) tick();
    chk("bp_drain", q.size(), 0);

    // Flush with three in flight and two buffered.
    do_flush();
    pix_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      req_valid = (i < 4) || (i == 8);
      tick();
    end
    chk("flush_pending", q.size(), 5);
    flush     = 1'b1;
    req_valid = 1'b1;
    tick();
    chk("flush_pv_before", obs_pv, 1);
    chk("flush_start", obs_start, 0);
    chk("flush_ready", obs_ready, 0);
    flush     = 1'b0;
    req_valid = 1'b0;
    pix_ready = 1'b1;
    tick();
    chk("flush_pv_after", obs_pv, 0);
    pv_seen = 0;
    repeat (20) tick();
    chk("flush_no_stale", pv_seen, 0);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("flush_restart_unit", obs_start, 1);
    repeat (12) tick();
    chk("flush_drain", q.size(), 0);

    // Underrun pulse follows a pull on an empty buffer by one cycle.
    pix_ready = 1'b0;
    tick();
    tick();
    chk("und_idle", obs_und, 0);
    pix_ready = 1'b1;
    tick();
    pix_ready = 1'b0;
    tick();
    chk("und_pulse", obs_und, 1);
    tick();
    chk("und_clear", obs_und, 0);

    // Asynchronous reset in the middle of a stream.
    req_valid = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("rst_pre_pv", obs_pv, 1);
    #3;
    rst = 1'b1;
    #1;
    chk("rst_async_outs", {req_ready, unit_start, pix_valid, pix_hit, pix_luma, underrun}, 0);
    @(negedge clk);
    @(negedge clk);
    q.delete();
    req_valid = 1'b0;
    pix_ready = 1'b1;
    rst       = 1'b0;
    pv_seen   = 0;
    repeat (20) tick();
    chk("rst_no_stale", pv_seen, 0);
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("rst_first_unit", obs_start, 1);
    repeat (12) tick();
    chk("rst_drain", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
